pipeline_ctrl: RTL

Central stall/flush sequencer for the 5-stage pipeline. It drives the PC write enable, the IF/ID register write/flush controls, the ID/EX bubble insert and the EX hold for multi-cycle ops.
It resolves load-use hazards, taken-branch flushes and multi-cycle EX operations, with fixed priority, through a small FSM and a down-counter. It also keeps a saturating stall-cycle performance counter.

---
 rtl/pipeline_ctrl_if.sv | 30 +++
 rtl/pipeline_ctrl.sv | 108 ++++++++++
 2 files changed

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the stall/flush sequencer.
// The master is the datapath side and the slave is the controller side.
interface pipeline_ctrl_if #(
  parameter int REG_W = 5
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             ex_memread;
  logic [REG_W-1:0] ex_rd;
  logic             branch_taken;
  logic             mc_start;
  logic             pc_write;
  logic             pc_sel;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             ex_hold;
  logic [15:0]      stall_cycles;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_memread, ex_rd, branch_taken, mc_start,
    input  pc_write, pc_sel, ifid_write, ifid_flush, idex_bubble, ex_hold, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rd, branch_taken, mc_start,
    output pc_write, pc_sel, ifid_write, ifid_flush, idex_bubble, ex_hold, stall_cycles
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, branch flushes,
// multi-cycle EX holds, plus a saturating stall-cycle counter.
module pipeline_ctrl #(
  parameter int REG_W        = 5,
  parameter int MC_LAT       = 4,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 4
) (
  input  logic            clk,
  input  logic            reset,
  pipeline_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {RUN, BUSY, FLUSH} state_e;

  localparam logic [REG_W-1:0] ZERO_REG = '0;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      stall_q, stall_d;
  logic             load_use;

  assign load_use = bus.ex_memread && (bus.ex_rd != ZERO_REG) &&
                    ((bus.ex_rd == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rd == bus.id_rt)));

  // Sequencing state; the first event in RUN wins and lower-priority ones are dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.branch_taken) begin
            if (FLUSH_CYCLES > 1) begin
              state_q <= FLUSH;
              cnt_q   <= CNT_W'(FLUSH_CYCLES - 2);
            end
          end else if (bus.mc_start) begin
            state_q <= BUSY;
            cnt_q   <= CNT_W'(MC_LAT - 2);
          end
        end
        BUSY, FLUSH: begin
          if (cnt_q == '0) state_q <= RUN;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  always_comb begin
    bus.pc_write    = 1'b1;
    bus.pc_sel      = 1'b0;
    bus.ifid_write  = 1'b1;
    bus.ifid_flush  = 1'b0;
    bus.idex_bubble = 1'b0;
    bus.ex_hold     = 1'b0;
    if (!reset) begin
      bus.pc_write    = 1'b0;
      bus.ifid_write  = 1'b0;
      bus.ifid_flush  = 1'b1;
      bus.idex_bubble = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.branch_taken) begin
            bus.pc_sel      = 1'b1;
            bus.ifid_flush  = 1'b1;
            bus.idex_bubble = 1'b1;
          end else if (bus.mc_start) begin
            bus.pc_write   = 1'b0;
            bus.ifid_write = 1'b0;
            bus.ex_hold    = 1'b1;
          end else if (load_use) begin
            bus.pc_write    = 1'b0;
            bus.ifid_write  = 1'b0;
            bus.idex_bubble = 1'b1;
          end
        end
        BUSY: begin
          bus.pc_write   = 1'b0;
          bus.ifid_write = 1'b0;
          bus.ex_hold    = 1'b1;
        end
        FLUSH: begin
          bus.ifid_flush  = 1'b1;
          bus.idex_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!bus.pc_write && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign bus.stall_cycles = stall_q;

endmodule
